// File: rtl/fft_step2_frame_ctrl.sv
// Frame sequencer feeding the step-2 FFT pipeline (BF20 -> BF21 -> BF22 -> reorder).
// Defining STALL_STATS_EN adds a saturating stall_cnt output that counts starved RUN cycles.
module fft_step2_frame_ctrl #(
    parameter int BEATS    = 32,
    parameter int PIPE_LAT = 40,
    parameter int FCNT_W   = 8
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              start,
    input  logic              in_valid,
    input  logic              in_last,
    output logic              in_ready,
    output logic              dp_valid,
    output logic signed [4:0] index_1_re,
    output logic signed [4:0] index_1_im,
    output logic signed [4:0] index_2_re,
    output logic signed [4:0] index_2_im,
    output logic              busy,
    output logic              frame_done,
    output logic              frame_err,
    output logic [FCNT_W-1:0] frame_cnt
`ifdef STALL_STATS_EN
    ,
    output logic [15:0]       stall_cnt
`endif
);

    localparam int BW = $clog2(BEATS);
    localparam int DW = $clog2(PIPE_LAT + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic [BW-1:0]     beat_cnt_q, beat_cnt_d;
    logic [DW-1:0]     drain_cnt_q, drain_cnt_d;
    logic              dp_valid_q, dp_valid_d;
    logic signed [4:0] idx1_re_q, idx1_re_d;
    logic signed [4:0] idx1_im_q, idx1_im_d;
    logic signed [4:0] idx2_re_q, idx2_re_d;
    logic signed [4:0] idx2_im_q, idx2_im_d;
    logic              frame_done_q, frame_done_d;
    logic              frame_err_q, frame_err_d;
    logic [FCNT_W-1:0] frame_cnt_q, frame_cnt_d;

    logic              accept;
    logic              last_beat;
    logic [4:0]        beat_grp;

    assign accept    = in_valid && (state_q == RUN);
    assign last_beat = (beat_cnt_q == BW'(BEATS - 1));
    // Each group of 8 beats shares one BF22 index-2 value.
    assign beat_grp  = 5'(beat_cnt_q >> 3);

    always_comb begin
        state_d      = state_q;
        beat_cnt_d   = beat_cnt_q;
        drain_cnt_d  = drain_cnt_q;
        dp_valid_d   = 1'b0;
        idx1_re_d    = idx1_re_q;
        idx1_im_d    = idx1_im_q;
        idx2_re_d    = idx2_re_q;
        idx2_im_d    = idx2_im_q;
        frame_done_d = 1'b0;
        frame_err_d  = 1'b0;
        frame_cnt_d  = frame_cnt_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = RUN;
                    beat_cnt_d = '0;
                end
            end
            RUN: begin
                if (accept) begin
                    dp_valid_d = 1'b1;
                    idx1_re_d  = $signed({2'b00, beat_cnt_q[2:0]});
                    idx1_im_d  = '0;
                    idx2_re_d  = $signed(beat_grp);
                    idx2_im_d  = $signed(5'd0 - beat_grp);
                    beat_cnt_d = beat_cnt_q + BW'(1);
                    // Either end marker closes the frame; disagreement between them is an error.
                    if (in_last || last_beat) begin
                        state_d     = DRAIN;
                        drain_cnt_d = '0;
                        frame_err_d = in_last ^ last_beat;
                    end
                end
            end
            DRAIN: begin
                if (drain_cnt_q == DW'(PIPE_LAT)) begin
                    state_d = DONE;
                end else begin
                    drain_cnt_d = drain_cnt_q + DW'(1);
                end
            end
            DONE: begin
                frame_done_d = 1'b1;
                frame_cnt_d  = frame_cnt_q + FCNT_W'(1);
                drain_cnt_d  = '0;
                state_d      = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= IDLE;
            beat_cnt_q   <= '0;
            drain_cnt_q  <= '0;
            dp_valid_q   <= 1'b0;
            idx1_re_q    <= '0;
            idx1_im_q    <= '0;
            idx2_re_q    <= '0;
            idx2_im_q    <= '0;
            frame_done_q <= 1'b0;
            frame_err_q  <= 1'b0;
            frame_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            beat_cnt_q   <= beat_cnt_d;
            drain_cnt_q  <= drain_cnt_d;
            dp_valid_q   <= dp_valid_d;
            idx1_re_q    <= idx1_re_d;
            idx1_im_q    <= idx1_im_d;
            idx2_re_q    <= idx2_re_d;
            idx2_im_q    <= idx2_im_d;
            frame_done_q <= frame_done_d;
            frame_err_q  <= frame_err_d;
            frame_cnt_q  <= frame_cnt_d;
        end
    end

`ifdef STALL_STATS_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (state_q == IDLE && start) begin
            stall_cnt_d = '0;
        end else if (state_q == RUN && !in_valid && stall_cnt_q != 16'hFFFF) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

    assign in_ready   = (state_q == RUN);
    assign busy       = (state_q != IDLE);
    assign dp_valid   = dp_valid_q;
    assign index_1_re = idx1_re_q;
    assign index_1_im = idx1_im_q;
    assign index_2_re = idx2_re_q;
    assign index_2_im = idx2_im_q;
    assign frame_done = frame_done_q;
    assign frame_err  = frame_err_q;
    assign frame_cnt  = frame_cnt_q;

endmodule
